// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiplier and restoring
// divider sharing one 2*WIDTH accumulator, results written to HI/LO.
module alu_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state;
  logic [CW-1:0]        counter;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;

  logic                 mden;
  logic                 divctr;
  logic                 sigctr;
  logic                 mt_op;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    mden   = MDctr[2];
    divctr = MDctr[1];
    sigctr = MDctr[0];
    mt_op  = ~MDctr[2] & MDctr[1];
    a_abs  = (sigctr && a[WIDTH-1]) ? -a : a;
    b_abs  = (sigctr && b[WIDTH-1]) ? -b : b;
  end

  // Mult: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
  // Div:  acc = {remainder, dividend/quotient}; shift left and trial-subtract the divisor.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opb};
    if (is_div) begin
      if (diff[WIDTH]) begin
        acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = {sum, acc[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      counter  <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (mden) begin
              state    <= StRun;
              busy     <= 1'b1;
              counter  <= '0;
              is_div   <= divctr;
              neg_q    <= sigctr & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r    <= sigctr & divctr & a[WIDTH-1];
              div_zero <= divctr & (b == '0);
              acc      <= divctr ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
              opb      <= divctr ? b_abs : a_abs;
            end else if (mt_op) begin
              if (sigctr) begin
                lo <= a;
              end else begin
                hi <= a;
              end
            end
          end
        end
        StRun: begin
          acc     <= acc_step;
          counter <= counter + CW'(1);
          if (counter == LastIter) begin
            counter <= '0;
            state   <= StFix;
          end
        end
        StFix: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (!div_zero) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit (WIDTH=32): directed corner cases plus random
// mult/div traffic checked against a 64-bit arithmetic reference model.
module tb_alu_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   MDctr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mhi;
  logic [W-1:0] mlo;
  logic         mdz;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .MDctr    (MDctr),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from integer arithmetic on the operands.
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'b100: begin
        up = {32'd0, x} * {32'd0, y};
        {mhi, mlo} = up;
        mdz = 1'b0;
      end
      3'b101: begin
        p = sx * sy;
        {mhi, mlo} = p;
        mdz = 1'b0;
      end
      3'b110: begin
        mdz = (y == 0);
        if (y != 0) begin
          mlo = x / y;
          mhi = x % y;
        end
      end
      default: begin
        mdz = (y == 0);
        if (y != 0) begin
          q = sx / sy;
          r = sx % sy;
          mlo = q[W-1:0];
          mhi = r[W-1:0];
        end
      end
    endcase
  endtask

  // Issue a mult/div in the current cycle and follow it to done. Returns in the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit poke);
    int cyc;
    int bc;
    start = 1'b1;
    MDctr = op;
    a     = x;
    b     = y;
    model_op(op, x, y);
    tick();
    start = 1'b0;
    MDctr = 3'b000;
    a     = $urandom;
    b     = $urandom;
    cyc   = 1;
    bc    = busy ? 1 : 0;
    check({tag, "_busy_on_accept"}, 64'(busy), 64'd1);
    check({tag, "_done_low_after_accept"}, 64'(done), 64'd0);
    while (!done && cyc < 100) begin
      if (poke && cyc == 5) begin
        start = 1'b1;
        MDctr = 3'b011;
        a     = 32'h1234;
      end else begin
        start = 1'b0;
        MDctr = 3'b000;
      end
      tick();
      cyc++;
      if (busy) bc++;
    end
    start = 1'b0;
    MDctr = 3'b000;
    check({tag, "_latency"}, 64'(cyc), 64'd34);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check({tag, "_hi"}, 64'(hi), 64'(mhi));
    check({tag, "_lo"}, 64'(lo), 64'(mlo));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(mdz));
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'(($urandom_range(0, 20)));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    MDctr = 3'b000;
    a     = '0;
    b     = '0;
    mhi   = '0;
    mlo   = '0;
    mdz   = 1'b0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;
    tick();

    run_op("multu_max", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    // Back-to-back: this start lands in the done cycle of the previous op.
    run_op("mult_neg", 3'b101, -32'sd3, 32'd7, 1'b1);
    check("mult_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    run_op("div_neg", 3'b111, -32'sd7, 32'd2, 1'b0);
    check("div_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    tick();
    run_op("divu_7_2", 3'b110, 32'd7, 32'd2, 1'b0);
    tick();
    run_op("div_ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi_const", 64'(hi), 64'h0);
    tick();

    // MTHI/MTLO and NOP in IDLE.
    start = 1'b1; MDctr = 3'b010; a = 32'h11;
    tick();
    mhi = 32'h11;
    start = 1'b1; MDctr = 3'b011; a = 32'h22;
    check("mthi_hi", 64'(hi), 64'(mhi));
    check("mthi_busy", 64'(busy), 64'd0);
    tick();
    mlo = 32'h22;
    start = 1'b1; MDctr = 3'b001; a = 32'h99; b = 32'h3;
    check("mtlo_lo", 64'(lo), 64'(mlo));
    check("mtlo_done", 64'(done), 64'd0);
    tick();
    start = 1'b0; MDctr = 3'b000;
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_hi", 64'(hi), 64'(mhi));
    check("nop_lo", 64'(lo), 64'(mlo));
    tick();

    run_op("divu_zero", 3'b110, 32'd5, 32'd0, 1'b0);
    check("divu_zero_flag", 64'(div_zero), 64'd1);
    check("divu_zero_done", 64'(done), 64'd1);
    check("divu_zero_hi_kept", 64'(hi), 64'h11);
    check("divu_zero_lo_kept", 64'(lo), 64'h22);
    run_op("multu_clear", 3'b100, 32'd6, 32'd9, 1'b0);
    tick();

    start = 1'b1; MDctr = 3'b011; a = 32'h1234;
    tick();
    mlo = 32'h1234;
    start = 1'b0; MDctr = 3'b000;
    check("mtlo_idle_lo", 64'(lo), 64'(mlo));
    check("mtlo_idle_done", 64'(done), 64'd0);

    // Synchronous reset partway through a multiply.
    start = 1'b1; MDctr = 3'b100; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    tick();
    start = 1'b0; MDctr = 3'b000;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mhi = '0; mlo = '0; mdz = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    tick();
    run_op("divu_100_7", 3'b110, 32'd100, 32'd7, 1'b0);
    check("divu_100_7_lo_const", 64'(lo), 64'd14);
    check("divu_100_7_hi_const", 64'(hi), 64'd2);

    for (int n = 0; n < 24; n++) begin
      logic [2:0] op;
      op = {1'b1, 2'($urandom_range(0, 3))};
      run_op("rand", op, pick_operand(), pick_operand(), n[0]);
      if (n % 3 == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
